// File: rtl/par_deser_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : par_deser_reg_if
// Description : Bus bundle for the serial-in / parallel-out receiver.
//               Carries the framed serial input (start, shiftin) and the
//               parallel output handshake (q, q_valid, q_ready).
//   master : the side that feeds serial bits and consumes q
//            (drives start, shiftin, q_ready; observes q, q_valid)
//   slave  : the receiver itself
//            (observes start, shiftin, q_ready; drives q, q_valid)
// Revision    : 1.0 - initial release
// ============================================================================
interface par_deser_reg_if #(
    parameter int SHIFT_WIDTH = 8
);
    logic                   start;
    logic                   shiftin;
    logic                   q_ready;
    logic [SHIFT_WIDTH-1:0] q;
    logic                   q_valid;

    modport master (
        output start,
        output shiftin,
        output q_ready,
        input  q,
        input  q_valid
    );

    modport slave (
        input  start,
        input  shiftin,
        input  q_ready,
        output q,
        output q_valid
    );
endinterface
`default_nettype wire

// File: rtl/par_deser_reg.sv
`default_nettype none
// ============================================================================
// Module      : par_deser_reg
// Description : Serial-in / parallel-out receiver. Collects SHIFT_WIDTH
//               serial bits framed by a start pulse into a parallel word and
//               presents it on bus.q with a valid/ready handshake.
// Ports       :
//   clock    in   rising-edge clock
//   aclr_n   in   asynchronous reset, active low
//   enable   in   clock enable; 0 freezes all state and ignores all inputs
//   sclr     in   synchronous clear (only while enable=1), highest priority
//   bus      slave modport: start, shiftin, q_ready in; q, q_valid out
//   busy     out  a frame is being received
//   overrun  out  sticky: a frame start was dropped while q was unaccepted
// Parameters  :
//   SHIFT_WIDTH     word width, >= 2
//   SHIFT_DIRECTION "LEFT"  : first received bit lands in q[MSB]
//                   "RIGHT" : first received bit lands in q[0]
// Revision    : 1.0 - initial release
// ============================================================================
module par_deser_reg #(
    parameter int SHIFT_WIDTH     = 8,
    parameter     SHIFT_DIRECTION = "LEFT"
) (
    input  wire logic           clock,
    input  wire logic           aclr_n,
    input  wire logic           enable,
    input  wire logic           sclr,
    par_deser_reg_if.slave      bus,
    output logic                busy,
    output logic                overrun
);

    localparam int CW = $clog2(SHIFT_WIDTH + 1);

    // Counter value while the final bit of a frame is on shiftin.
    localparam logic [CW-1:0] LAST_CNT = CW'(SHIFT_WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] ZERO_CNT = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [SHIFT_WIDTH-1:0] sh_q;
    logic [SHIFT_WIDTH-1:0] word_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   overrun_q;

    // Shift-register value including the bit currently on shiftin. The
    // completing edge loads q from this, so the final bit is not missed.
    logic [SHIFT_WIDTH-1:0] sh_d;

    generate
        if (SHIFT_DIRECTION == "RIGHT") begin : g_right
            assign sh_d = {bus.shiftin, sh_q[SHIFT_WIDTH-1:1]};
        end else begin : g_left
            assign sh_d = {sh_q[SHIFT_WIDTH-2:0], bus.shiftin};
        end
    endgenerate

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= ZERO_CNT;
            sh_q      <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (enable) begin
            if (sclr) begin
                state_q   <= S_IDLE;
                cnt_q     <= ZERO_CNT;
                sh_q      <= '0;
                word_q    <= '0;
                valid_q   <= 1'b0;
                busy_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // start coincides with bit 1 of the frame.
                        if (bus.start) begin
                            sh_q    <= sh_d;
                            cnt_q   <= ONE_CNT;
                            busy_q  <= 1'b1;
                            state_q <= S_RECV;
                        end
                    end

                    S_RECV: begin
                        // start is ignored mid-frame.
                        sh_q <= sh_d;
                        if (cnt_q == LAST_CNT) begin
                            word_q  <= sh_d;
                            valid_q <= 1'b1;
                            cnt_q   <= ZERO_CNT;
                            busy_q  <= 1'b0;
                            state_q <= S_FULL;
                        end else begin
                            cnt_q <= cnt_q + ONE_CNT;
                        end
                    end

                    S_FULL: begin
                        if (bus.q_ready) begin
                            valid_q <= 1'b0;
                            if (bus.start) begin
                                // Accept and begin the next frame in one cycle.
                                sh_q    <= sh_d;
                                cnt_q   <= ONE_CNT;
                                busy_q  <= 1'b1;
                                state_q <= S_RECV;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else if (bus.start) begin
                            // No room for a new frame: drop it and flag it.
                            overrun_q <= 1'b1;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= ZERO_CNT;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.q       = word_q;
    assign bus.q_valid = valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_par_deser_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_par_deser_reg
// Description : Directed self-checking bench for par_deser_reg. Two instances
//               (LEFT and RIGHT) receive the same serial stream; expected
//               words are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_par_deser_reg;

    localparam int W = 8;

    logic clock = 1'b0;
    logic aclr_n;
    logic enable;
    logic sclr;
    logic busy_l, overrun_l;
    logic busy_r, overrun_r;

    int checks   = 0;
    int failures = 0;

    par_deser_reg_if #(.SHIFT_WIDTH(W)) if_l ();
    par_deser_reg_if #(.SHIFT_WIDTH(W)) if_r ();

    // Right-shifting instance sees exactly the same serial stream.
    assign if_r.start   = if_l.start;
    assign if_r.shiftin = if_l.shiftin;
    assign if_r.q_ready = if_l.q_ready;

    par_deser_reg #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION("LEFT")) u_left (
        .clock   (clock),
        .aclr_n  (aclr_n),
        .enable  (enable),
        .sclr    (sclr),
        .bus     (if_l.slave),
        .busy    (busy_l),
        .overrun (overrun_l)
    );

    par_deser_reg #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION("RIGHT")) u_right (
        .clock   (clock),
        .aclr_n  (aclr_n),
        .enable  (enable),
        .sclr    (sclr),
        .bus     (if_r.slave),
        .busy    (busy_r),
        .overrun (overrun_r)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the rising edge, settle.
    task automatic step(input logic s, input logic b, input logic r);
        if_l.start   = s;
        if_l.shiftin = b;
        if_l.q_ready = r;
        @(posedge clock);
        #1;
    endtask

    // Send bits v[hi] down to v[lo], start asserted on the first if requested.
    task automatic send_range(input logic [7:0] v, input int hi, input int lo, input logic with_start);
        for (int i = hi; i >= lo; i--) begin
            step(with_start && (i == hi), v[i], 1'b0);
        end
    endtask

    initial begin
        enable       = 1'b1;
        sclr         = 1'b0;
        if_l.start   = 1'b0;
        if_l.shiftin = 1'b0;
        if_l.q_ready = 1'b0;
        aclr_n       = 1'b1;
        #2 aclr_n    = 1'b0;
        #1;
        check("rst_q",       if_l.q,       8'h00);
        check("rst_valid",   if_l.q_valid, 8'h00);
        check("rst_busy",    busy_l,       8'h00);
        check("rst_overrun", overrun_l,    8'h00);
        #9 aclr_n = 1'b1;
        @(posedge clock);
        #1;

        // MSB-first 0,1,0,1,1,1,0,1 -> LEFT 5D, RIGHT BA
        send_range(8'h5D, 7, 1, 1'b1);
        check("recv7_busy",  busy_l,       8'h01);
        check("recv7_valid", if_l.q_valid, 8'h00);
        check("recv7_q",     if_l.q,       8'h00);
        send_range(8'h5D, 0, 0, 1'b0);
        check("left_q",      if_l.q,       8'h5D);
        check("right_q",     if_r.q,       8'hBA);
        check("full_valid",  if_l.q_valid, 8'h01);
        check("full_busy",   busy_l,       8'h00);

        // Accept the word
        step(1'b0, 1'b0, 1'b1);
        check("acc_valid",   if_l.q_valid, 8'h00);
        check("acc_q_hold",  if_l.q,       8'h5D);

        // Reset mid-frame after 3 bits
        send_range(8'hFF, 7, 5, 1'b1);
        check("mid_busy",    busy_l,       8'h01);
        check("mid_q_old",   if_l.q,       8'h5D);
        aclr_n = 1'b0;
        #2;
        check("arst_q",      if_l.q,       8'h00);
        check("arst_valid",  if_l.q_valid, 8'h00);
        check("arst_busy",   busy_l,       8'h00);
        aclr_n = 1'b1;
        @(posedge clock);
        #1;
        send_range(8'h5D, 7, 0, 1'b1);
        check("clean_left",  if_l.q,       8'h5D);
        check("clean_right", if_r.q,       8'hBA);
        check("clean_valid", if_l.q_valid, 8'h01);

        // Backpressure: start while FULL and not ready
        step(1'b1, 1'b1, 1'b0);
        check("ovr_set",     overrun_l,    8'h01);
        check("ovr_q",       if_l.q,       8'h5D);
        check("ovr_valid",   if_l.q_valid, 8'h01);
        check("ovr_busy",    busy_l,       8'h00);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("ovr_hold_q",  if_l.q,       8'h5D);
        check("ovr_hold_v",  if_l.q_valid, 8'h01);
        step(1'b0, 1'b0, 1'b1);
        check("ovr_acc_v",   if_l.q_valid, 8'h00);
        check("ovr_sticky",  overrun_l,    8'h01);
        step(1'b0, 1'b0, 1'b0);
        check("ovr_sticky2", overrun_l,    8'h01);
        sclr = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        sclr = 1'b0;
        check("sclr_ovr",    overrun_l,    8'h00);
        check("sclr_q",      if_l.q,       8'h00);
        check("sclr_busy",   busy_l,       8'h00);

        // Enable gating after bit 4
        send_range(8'h5D, 7, 4, 1'b1);
        enable = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("gate_busy",   busy_l,       8'h01);
        check("gate_valid",  if_l.q_valid, 8'h00);
        enable = 1'b1;
        send_range(8'h5D, 3, 0, 1'b0);
        check("gate_left",   if_l.q,       8'h5D);
        check("gate_right",  if_r.q,       8'hBA);
        check("gate_valid2", if_l.q_valid, 8'h01);
        enable = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        check("gate_nohs",   if_l.q_valid, 8'h01);
        enable = 1'b1;

        // Back-to-back: accept and start 8'h81 in the same cycle
        step(1'b1, 1'b1, 1'b1);
        check("b2b_valid0",  if_l.q_valid, 8'h00);
        check("b2b_busy",    busy_l,       8'h01);
        for (int i = 6; i >= 1; i--) begin
            step(1'b0, 1'b0, 1'b0);
            check("b2b_low",  if_l.q_valid, 8'h00);
        end
        step(1'b0, 1'b1, 1'b0);
        check("b2b_left",    if_l.q,       8'h81);
        check("b2b_right",   if_r.q,       8'h81);
        check("b2b_valid",   if_l.q_valid, 8'h01);
        check("b2b_ovr",     overrun_l,    8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
